neuron_row_scheduler: RTL and testbench

NEURON_ROW_SCHEDULER -- requirements
Module: neuron_row_scheduler

---
 rtl/neuron_row_scheduler.sv | 145 ++++++++++++++
 tb/tb_neuron_row_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_row_scheduler.sv
// Sequences one layer: per neuron, kicks the weight reader, MACs weights against activations, emits the sum.
// Latency: start->rd_start 2 cycles, rd_done->result_valid 1 cycle, last result->done 1 cycle; no backpressure on results.
module neuron_row_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] layer_base_addr,
    input  logic [31:0] neuron_count,
    input  logic [31:0] weight_count,
    output logic [31:0] rd_base_addr,
    output logic [31:0] rd_neuron_index,
    output logic [31:0] rd_weight_count,
    output logic        rd_start,
    input  logic        rd_done,
    input  logic        rd_weight_valid,
    input  logic [7:0]  rd_weight_out,
    input  logic [31:0] rd_weight_index,
    output logic [15:0] act_addr,
    input  logic [7:0]  act_data,
    output logic        result_valid,
    output logic [31:0] result_data,
    output logic [31:0] result_index,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {IDLE, ISSUE, STREAM, EMIT, FINISH} state_t;

    state_t      state_q;
    logic [31:0] base_q, ncount_q, wcount_q;
    logic [31:0] n_q, k_q, rcvd_q, acc_q;
    logic [31:0] rd_neuron_index_q, result_data_q, result_index_q;
    logic        rd_start_q, result_valid_q, busy_q, done_q, error_q;

    logic signed [15:0] prod;
    logic [31:0]        acc_d, rcvd_d;

    // Accumulator and count as they stand once this cycle's weight (if any) is folded in.
    always_comb begin
        prod   = $signed(rd_weight_out) * $signed(act_data);
        acc_d  = acc_q;
        rcvd_d = rcvd_q;
        if (rd_weight_valid) begin
            acc_d  = acc_q + {{16{prod[15]}}, prod};
            rcvd_d = rcvd_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            base_q            <= '0;
            ncount_q          <= '0;
            wcount_q          <= '0;
            n_q               <= '0;
            k_q               <= '0;
            rcvd_q            <= '0;
            acc_q             <= '0;
            rd_neuron_index_q <= '0;
            result_data_q     <= '0;
            result_index_q    <= '0;
            rd_start_q        <= 1'b0;
            result_valid_q    <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            error_q           <= 1'b0;
        end else begin
            rd_start_q     <= 1'b0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            if (state_q != IDLE && abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            base_q   <= layer_base_addr;
                            ncount_q <= neuron_count;
                            wcount_q <= weight_count;
                            n_q      <= '0;
                            error_q  <= 1'b0;
                            busy_q   <= 1'b1;
                            state_q  <= (neuron_count == 32'd0) ? FINISH : ISSUE;
                        end
                    end
                    ISSUE: begin
                        rd_start_q        <= 1'b1;
                        rd_neuron_index_q <= n_q;
                        acc_q             <= '0;
                        k_q               <= '0;
                        rcvd_q            <= '0;
                        state_q           <= STREAM;
                    end
                    STREAM: begin
                        if (rd_weight_valid) begin
                            acc_q  <= acc_d;
                            rcvd_q <= rcvd_d;
                            k_q    <= k_q + 32'd1;
                            if (rd_weight_index != k_q) error_q <= 1'b1;
                        end
                        if (rd_done) begin
                            if (rcvd_d != wcount_q) error_q <= 1'b1;
                            result_valid_q <= 1'b1;
                            result_data_q  <= acc_d;
                            result_index_q <= n_q;
                            state_q        <= EMIT;
                        end
                    end
                    EMIT: begin
                        if (n_q == ncount_q - 32'd1) begin
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            n_q     <= n_q + 32'd1;
                            state_q <= ISSUE;
                        end
                    end
                    FINISH: begin
                        // Coming from EMIT the pulse is already out; the empty-layer path raises it here.
                        done_q  <= ~done_q;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rd_base_addr    = base_q;
    assign rd_weight_count = wcount_q;
    assign rd_neuron_index = rd_neuron_index_q;
    assign rd_start        = rd_start_q;
    assign act_addr        = k_q[15:0];
    assign result_valid    = result_valid_q;
    assign result_data     = result_data_q;
    assign result_index    = result_index_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;

endmodule

// File: tb/tb_neuron_row_scheduler.sv
// Directed bench: behavioural weight reader and activation RAM around the scheduler, hand-computed results.
// Latency of rd_start, result_valid and done is measured against the cycle counter.
module tb_neuron_row_scheduler;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [31:0] layer_base_addr, neuron_count, weight_count;
    logic [31:0] rd_base_addr, rd_neuron_index, rd_weight_count, rd_weight_index;
    logic        rd_start, rd_done, rd_weight_valid;
    logic [7:0]  rd_weight_out, act_data;
    logic [15:0] act_addr;
    logic        result_valid, busy, done, error;
    logic [31:0] result_data, result_index;

    always #5 clk = ~clk;

    neuron_row_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .layer_base_addr(layer_base_addr), .neuron_count(neuron_count), .weight_count(weight_count),
        .rd_base_addr(rd_base_addr), .rd_neuron_index(rd_neuron_index), .rd_weight_count(rd_weight_count),
        .rd_start(rd_start), .rd_done(rd_done), .rd_weight_valid(rd_weight_valid),
        .rd_weight_out(rd_weight_out), .rd_weight_index(rd_weight_index),
        .act_addr(act_addr), .act_data(act_data),
        .result_valid(result_valid), .result_data(result_data), .result_index(result_index),
        .busy(busy), .done(done), .error(error)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [7:0] wmem [0:3][0:3];
    logic signed [7:0] amem [0:3];
    int n_send;
    bit skip, done_last;

    int n_checks = 0, n_pass = 0;
    int n_res, n_done, n_rs, start_cyc, done_cyc, last_res_cyc, done_at;
    int res_data [0:7];
    int res_idx  [0:7];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Activation RAM: follows act_addr once per cycle.
    initial begin
        act_data = '0;
        forever begin
            @(negedge clk);
            act_data = amem[act_addr[1:0]];
        end
    end

    // Weight reader: one weight every other cycle, then rd_done (optionally alongside the last weight).
    initial begin
        logic [1:0] nn;
        rd_done = 1'b0; rd_weight_valid = 1'b0; rd_weight_out = '0; rd_weight_index = '0;
        forever begin
            @(negedge clk);
            if (rd_start) begin
                nn = rd_neuron_index[1:0];
                for (int j = 0; j < n_send; j++) begin
                    @(negedge clk);
                    rd_weight_valid = 1'b1;
                    rd_weight_out   = wmem[nn][j];
                    rd_weight_index = (skip && j > 0) ? 32'(j + 1) : 32'(j);
                    if (done_last && j == n_send - 1) begin
                        rd_done  = 1'b1;
                        done_cyc = cyc;
                    end
                    @(negedge clk);
                    rd_weight_valid = 1'b0;
                    rd_done = 1'b0;
                end
                if (!(done_last && n_send > 0)) begin
                    @(negedge clk);
                    rd_done  = 1'b1;
                    done_cyc = cyc;
                    @(negedge clk);
                    rd_done = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_start) begin
                if (n_rs == 0) check("rdstart_lat", cyc - start_cyc, 2);
                n_rs++;
            end
            if (result_valid) begin
                check("result_lat", cyc - done_cyc, 1);
                if (n_res < 8) begin
                    res_data[n_res] = result_data;
                    res_idx[n_res]  = result_index;
                end
                n_res++;
                last_res_cyc = cyc;
            end
            if (done) begin
                n_done++;
                done_at = cyc;
            end
        end
    end

    task automatic do_start(input logic [31:0] base, input logic [31:0] nc, input logic [31:0] wc);
        @(negedge clk);
        layer_base_addr = base; neuron_count = nc; weight_count = wc;
        n_res = 0; n_done = 0; n_rs = 0;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        for (int i = 0; i < maxc && n_done == 0; i++) @(negedge clk);
        check("done_seen", n_done > 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_rs(input int target, input int maxc);
        for (int i = 0; i < maxc && n_rs < target; i++) @(negedge clk);
        check("rd_start_seen", n_rs >= target, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        layer_base_addr = '0; neuron_count = '0; weight_count = '0;
        n_send = 0; skip = 1'b0; done_last = 1'b0;
        n_res = 0; n_done = 0; n_rs = 0; start_cyc = 0; done_cyc = 0; last_res_cyc = 0; done_at = 0;
        amem = '{8'sd4, 8'sd5, 8'sd6, 8'sd0};
        wmem[0] = '{8'sd1, 8'sd2, 8'sd3, 8'sd0};
        wmem[1] = '{-8'sd1, -8'sd2, -8'sd3, 8'sd0};
        wmem[2] = '{8'sd0, 8'sd0, 8'sd0, 8'sd0};
        wmem[3] = '{8'sd0, 8'sd0, 8'sd0, 8'sd0};

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_rd_start", rd_start, 0);
        check("rst_error", error, 0);
        check("rst_act_addr", act_addr, 0);
        check("rst_result_data", result_data, 0);
        check("rst_rd_neuron_index", rd_neuron_index, 0);
        rst = 1'b0;

        // Two neurons, three weights each: 1*4+2*5+3*6 = 32 and its negation.
        n_send = 3;
        do_start(32'h1000, 2, 3);
        check("latched_base", rd_base_addr, 32'h1000);
        check("latched_wcount", rd_weight_count, 3);
        check("busy_after_start", busy, 1);
        wait_done(200);
        check("t1_nres", n_res, 2);
        check("t1_res0", res_data[0], 32);
        check("t1_idx0", res_idx[0], 0);
        check("t1_res1", res_data[1], -32);
        check("t1_idx1", res_idx[1], 1);
        check("t1_ndone", n_done, 1);
        check("t1_done_lat", done_at - last_res_cyc, 1);
        check("t1_error", error, 0);
        check("t1_busy", busy, 0);

        // Zero weights per neuron.
        n_send = 0;
        do_start(32'h0, 3, 0);
        wait_done(200);
        check("t2_nres", n_res, 3);
        for (int i = 0; i < 3; i++) begin
            check("t2_res", res_data[i], 0);
            check("t2_idx", res_idx[i], i);
        end
        check("t2_ndone", n_done, 1);
        check("t2_error", error, 0);

        // Empty layer.
        do_start(32'h0, 0, 5);
        wait_done(50);
        check("t3_done_lat", done_at - start_cyc, 2);
        check("t3_nrs", n_rs, 0);
        check("t3_nres", n_res, 0);
        check("t3_ndone", n_done, 1);

        // Most negative operands, last weight arriving with rd_done: 4 * 16384.
        amem = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128};
        wmem[0] = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128};
        n_send = 4; done_last = 1'b1;
        do_start(32'h0, 1, 4);
        wait_done(200);
        check("t4_res", res_data[0], 65536);
        check("t4_error", error, 0);
        done_last = 1'b0;

        // Short read: 1*4 + 2*5 = 14, error sticky, then cleared by the next start.
        amem = '{8'sd4, 8'sd5, 8'sd6, 8'sd0};
        wmem[0] = '{8'sd1, 8'sd2, 8'sd3, 8'sd0};
        n_send = 2;
        do_start(32'h0, 1, 3);
        wait_done(200);
        check("t5_nres", n_res, 1);
        check("t5_res", res_data[0], 14);
        check("t5_error", error, 1);
        repeat (5) @(negedge clk);
        check("t5_error_sticky", error, 1);
        n_send = 3;
        do_start(32'h0, 1, 3);
        check("t5_error_cleared", error, 0);
        wait_done(200);
        check("t5_res_ok", res_data[0], 32);
        check("t5_error_ok", error, 0);
        skip = 1'b1;
        do_start(32'h0, 1, 3);
        wait_done(200);
        check("t5_skip_error", error, 1);
        check("t5_skip_res", res_data[0], 32);
        skip = 1'b0;

        // Abort while streaming neuron 1; a start during the run must be ignored.
        do_start(32'h2000, 2, 3);
        wait_rs(1, 50);
        repeat (2) @(negedge clk);
        layer_base_addr = 32'h3000; neuron_count = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t6_base_kept", rd_base_addr, 32'h2000);
        check("t6_busy", busy, 1);
        wait_rs(2, 100);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t6_abort_busy", busy, 0);
        check("t6_abort_error", error, 0);
        repeat (20) @(negedge clk);
        check("t6_nres", n_res, 1);
        check("t6_res0", res_data[0], 32);
        check("t6_ndone", n_done, 0);
        check("t6_nrs", n_rs, 2);

        // Reset in the middle of a run.
        do_start(32'h0, 2, 3);
        wait_rs(1, 50);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t7_busy", busy, 0);
        check("t7_act_addr", act_addr, 0);
        check("t7_result_data", result_data, 0);
        repeat (30) @(negedge clk);
        check("t7_ndone", n_done, 0);
        check("t7_nres", n_res, 0);
        check("t7_busy_late", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
